// File: rtl/la_capture_pkg.sv
// la_capture_pkg
// Shared definitions for the logic-analyser capture engine: the capture
// state encoding, the trigger-mode encodings and the trigger-qualification
// helper used by la_capture_core.
package la_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_WAIT_TRIG,
    ST_POST,
    ST_DONE
  } la_state_t;

  localparam logic [1:0] TRIG_LEVEL  = 2'd0;
  localparam logic [1:0] TRIG_RISE   = 2'd1;
  localparam logic [1:0] TRIG_CHANGE = 2'd2;
  localparam logic [1:0] TRIG_NOW    = 2'd3;

  // Folds the per-cycle match terms into a single hit for the selected mode.
  // matchNow and changed are already masked by the caller, so an all-zero
  // mask naturally makes level-match always hit and any-change never hit.
  function automatic logic trigHit(input logic [1:0] mode,
                                   input logic       matchNow,
                                   input logic       matchPrev,
                                   input logic       changed);
    logic hit;
    hit = 1'b0;
    case (mode)
      TRIG_LEVEL:  hit = matchNow;
      TRIG_RISE:   hit = matchNow & ~matchPrev;
      TRIG_CHANGE: hit = changed;
      TRIG_NOW:    hit = 1'b1;
      default:     hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/la_sample_ram.sv
// la_sample_ram
// Simple dual-port sample buffer: one synchronous write port and one
// registered read port, both on sampleClk. Coded in the plain two-process
// form block-RAM inference expects; only the read output register carries
// a reset so rdData comes out of reset as zero.
//
// Ports:
//   sampleClk  capture clock
//   resetN     asynchronous active-low reset (read register only)
//   wrEn       write strobe
//   wrAddr     physical write address
//   wrData     sample to store
//   rdAddr     physical read address
//   rdData     registered read data, valid one cycle after rdAddr
module la_sample_ram #(
  parameter int DATA_W = 22,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sampleClk,
  input  logic              resetN,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: no reset on the array so the tools can map it to block RAM.
  always_ff @(posedge sampleClk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Registered read port. The read side never looks at the write side, so
  // there is no read-during-write bypass; the capture core only promises
  // data once writing has stopped.
  always_ff @(posedge sampleClk or negedge resetN) begin
    if (!resetN) begin
      rdData <= '0;
    end else begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/la_capture_core.sv
// la_capture_core
// On-chip logic-analyser capture engine. Every active cycle the probe bus
// is written into a circular buffer; the trigger bus is qualified against a
// latched mask/value/mode, and the capture is framed so that the trigger
// sample lands at chronological index trigIndex (the effective pre-trigger
// depth). After capture, samples are read back oldest-first via rdAddr.
//
// Ports:
//   sampleClk     capture clock; all logic is on this clock
//   resetN        asynchronous active-low reset
//   armIn         one-cycle pulse starting a capture (IDLE/DONE only)
//   abortIn       one-cycle pulse forcing IDLE; beats armIn
//   trigMask      1 = bit takes part in the trigger
//   trigValue     trigger compare value
//   trigMode      0 level, 1 match-entry, 2 any-change, 3 immediate
//   preTrigCount  samples kept before the trigger (clamped to DEPTH-2)
//   dataIn        probe data
//   trigIn        trigger probe
//   rdAddr        chronological read index, 0 = oldest sample
//   rdData        sample at rdAddr, one cycle later
//   busy          high from arm until done
//   triggered     high once the trigger has been accepted
//   done          capture complete, buffer stable
//   trigIndex     chronological index of the trigger sample
module la_capture_core
  import la_capture_pkg::*;
#(
  parameter int DATA_W = 22,
  parameter int TRIG_W = 15,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sampleClk,
  input  logic              resetN,
  input  logic              armIn,
  input  logic              abortIn,
  input  logic [TRIG_W-1:0] trigMask,
  input  logic [TRIG_W-1:0] trigValue,
  input  logic [1:0]        trigMode,
  input  logic [ADDR_W-1:0] preTrigCount,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [TRIG_W-1:0] trigIn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trigIndex
);

  // The circular-buffer arithmetic relies on natural wrap of ADDR_W bits.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
    $error("la_capture_core: DEPTH must be a power of two and at least 4");
  end

  localparam logic [ADDR_W-1:0] PRE_MAX  = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  la_state_t         state;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] preEff;
  logic [ADDR_W-1:0] startPhys;
  logic [TRIG_W-1:0] cfgMask;
  logic [TRIG_W-1:0] cfgValue;
  logic [1:0]        cfgMode;
  logic [TRIG_W-1:0] prevTrig;
  logic              prevMatch;

  logic              armAccept;
  logic              writing;
  logic [ADDR_W-1:0] armPre;
  logic [TRIG_W-1:0] histMask;
  logic [TRIG_W-1:0] histValue;
  logic              matchNow;
  logic              histMatch;
  logic              changed;
  logic              hit;
  logic [ADDR_W-1:0] rdPhys;

  // Trigger qualification and arm decode. The match history is tracked
  // every cycle; on the arm cycle it is computed against the incoming
  // configuration so that a trigger already matching at arm time counts
  // as "previously matched" and does not fire a match-entry trigger.
  always_comb begin
    armAccept = armIn && !abortIn && (state == ST_IDLE || state == ST_DONE);
    writing   = (state == ST_PREFILL) || (state == ST_WAIT_TRIG) || (state == ST_POST);
    armPre    = (preTrigCount > PRE_MAX) ? PRE_MAX : preTrigCount;
    histMask  = armAccept ? trigMask  : cfgMask;
    histValue = armAccept ? trigValue : cfgValue;
    matchNow  = ((trigIn ^ cfgValue) & cfgMask) == '0;
    histMatch = ((trigIn ^ histValue) & histMask) == '0;
    changed   = |((trigIn ^ prevTrig) & cfgMask);
    hit       = trigHit(cfgMode, matchNow, prevMatch, changed);
    rdPhys    = startPhys + rdAddr;
  end

  // Capture FSM with its counters. count is reused: it counts pre-trigger
  // writes up in PREFILL and the remaining post-trigger writes down in
  // POST. The pre-trigger depth is clamped to DEPTH-2 so at least one
  // post-trigger sample always follows the trigger sample.
  always_ff @(posedge sampleClk or negedge resetN) begin
    if (!resetN) begin
      state     <= ST_IDLE;
      wrPtr     <= '0;
      count     <= '0;
      preEff    <= '0;
      startPhys <= '0;
      cfgMask   <= '0;
      cfgValue  <= '0;
      cfgMode   <= TRIG_LEVEL;
      prevTrig  <= '0;
      prevMatch <= 1'b0;
      busy      <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
      trigIndex <= '0;
    end else begin
      prevMatch <= histMatch;
      prevTrig  <= trigIn;
      if (writing) begin
        wrPtr <= wrPtr + ONE;
      end
      if (abortIn) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        triggered <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (armIn) begin
              cfgMask   <= trigMask;
              cfgValue  <= trigValue;
              cfgMode   <= trigMode;
              preEff    <= armPre;
              trigIndex <= armPre;
              count     <= '0;
              busy      <= 1'b1;
              triggered <= 1'b0;
              done      <= 1'b0;
              state     <= (armPre == '0) ? ST_WAIT_TRIG : ST_PREFILL;
            end
          end
          ST_PREFILL: begin
            count <= count + ONE;
            if (count == preEff - ONE) begin
              state <= ST_WAIT_TRIG;
            end
          end
          ST_WAIT_TRIG: begin
            if (hit) begin
              startPhys <= wrPtr - preEff;
              triggered <= 1'b1;
              count     <= LAST_IDX - preEff;
              state     <= ST_POST;
            end
          end
          ST_POST: begin
            count <= count - ONE;
            if (count == ONE) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  la_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) uRam (
    .sampleClk (sampleClk),
    .resetN    (resetN),
    .wrEn      (writing),
    .wrAddr    (wrPtr),
    .wrData    (dataIn),
    .rdAddr    (rdPhys),
    .rdData    (rdData)
  );

endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core
// Directed bench for la_capture_core at DEPTH=16, DATA_W=8, TRIG_W=4.
// dataIn carries a free-running cycle count so every stored sample
// identifies the cycle it was captured in. Inputs change on the falling
// edge and outputs are checked on the falling edge.
module tb_la_capture_core;

  localparam int DATA_W = 8;
  localparam int TRIG_W = 4;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              sampleClk = 1'b0;
  logic              resetN;
  logic              armIn;
  logic              abortIn;
  logic [TRIG_W-1:0] trigMask;
  logic [TRIG_W-1:0] trigValue;
  logic [1:0]        trigMode;
  logic [ADDR_W-1:0] preTrigCount;
  logic [DATA_W-1:0] dataIn;
  logic [TRIG_W-1:0] trigIn;
  logic [ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0] rdData;
  logic              busy;
  logic              triggered;
  logic              done;
  logic [ADDR_W-1:0] trigIndex;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int armCyc   = 0;
  int trigCyc  = 0;

  la_capture_core #(
    .DATA_W (DATA_W),
    .TRIG_W (TRIG_W),
    .DEPTH  (DEPTH)
  ) dut (
    .sampleClk    (sampleClk),
    .resetN       (resetN),
    .armIn        (armIn),
    .abortIn      (abortIn),
    .trigMask     (trigMask),
    .trigValue    (trigValue),
    .trigMode     (trigMode),
    .preTrigCount (preTrigCount),
    .dataIn       (dataIn),
    .trigIn       (trigIn),
    .rdAddr       (rdAddr),
    .rdData       (rdData),
    .busy         (busy),
    .triggered    (triggered),
    .done         (done),
    .trigIndex    (trigIndex)
  );

  always #5 sampleClk = ~sampleClk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive the pulses, trigger bus and current cycle count,
  // let the rising edge sample them, then return at the falling edge.
  task automatic applyStimulus(input logic arm, input logic abort,
                               input logic [TRIG_W-1:0] trig);
    armIn   = arm;
    abortIn = abort;
    trigIn  = trig;
    dataIn  = DATA_W'(cyc);
    @(posedge sampleClk);
    cyc++;
    @(negedge sampleClk);
    armIn   = 1'b0;
    abortIn = 1'b0;
  endtask

  // Present a read index, wait out the registered read, compare.
  task automatic readCheck(input string tag, input int addr, input int expected);
    rdAddr = ADDR_W'(addr);
    applyStimulus(1'b0, 1'b0, trigIn);
    checkOutput(tag, 32'(rdData), 32'(expected & 255));
  endtask

  initial begin
    resetN       = 1'b0;
    armIn        = 1'b0;
    abortIn      = 1'b0;
    trigMask     = '0;
    trigValue    = '0;
    trigMode     = 2'd0;
    preTrigCount = '0;
    dataIn       = '0;
    trigIn       = '0;
    rdAddr       = '0;
    @(negedge sampleClk);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset triggered", 32'(triggered), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset trigIndex", 32'(trigIndex), 0);
    checkOutput("reset rdData", 32'(rdData), 0);
    resetN = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0);

    // Level match on 5 with a 0..F ramp and four pre-trigger samples.
    trigMask = 4'hF; trigValue = 4'd5; trigMode = 2'd0; preTrigCount = 4'd4;
    armCyc = cyc;
    applyStimulus(1'b1, 1'b0, 4'd0);
    checkOutput("t1 busy after arm", 32'(busy), 1);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b0, TRIG_W'(i));
    checkOutput("t1 not triggered before 5", 32'(triggered), 0);
    trigCyc = cyc;
    applyStimulus(1'b0, 1'b0, 4'd5);
    checkOutput("t1 triggered", 32'(triggered), 1);
    for (int i = 6; i <= 15; i++) applyStimulus(1'b0, 1'b0, TRIG_W'(i));
    checkOutput("t1 not done after 10 posts", 32'(done), 0);
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t1 done", 32'(done), 1);
    checkOutput("t1 busy low", 32'(busy), 0);
    checkOutput("t1 trigIndex", 32'(trigIndex), 4);
    readCheck("t1 rd trigger", 4, trigCyc);
    for (int k = 0; k < DEPTH; k++) begin
      readCheck($sformatf("t1 rd %0d", k), k, armCyc + 1 + k);
    end

    // Match-entry: trigger already matching at arm must not fire.
    applyStimulus(1'b0, 1'b0, 4'd3);
    trigValue = 4'd3; trigMode = 2'd1; preTrigCount = 4'd2;
    applyStimulus(1'b1, 1'b0, 4'd3);
    repeat (8) applyStimulus(1'b0, 1'b0, 4'd3);
    checkOutput("t2 held match no trigger", 32'(triggered), 0);
    checkOutput("t2 still busy", 32'(busy), 1);
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t2 drop no trigger", 32'(triggered), 0);
    trigCyc = cyc;
    applyStimulus(1'b0, 1'b0, 4'd3);
    checkOutput("t2 re-entry trigger", 32'(triggered), 1);
    repeat (12) applyStimulus(1'b0, 1'b0, 4'd3);
    checkOutput("t2 not done early", 32'(done), 0);
    applyStimulus(1'b0, 1'b0, 4'd3);
    checkOutput("t2 done", 32'(done), 1);
    checkOutput("t2 trigIndex", 32'(trigIndex), 2);
    readCheck("t2 rd trigger", 2, trigCyc);
    readCheck("t2 rd before trigger", 1, trigCyc - 1);

    // Any-change on bit0 only.
    trigMask = 4'h1; trigValue = 4'd0; trigMode = 2'd2; preTrigCount = 4'd1;
    applyStimulus(1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd2);
    applyStimulus(1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd2);
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t3 masked toggles ignored", 32'(triggered), 0);
    trigCyc = cyc;
    applyStimulus(1'b0, 1'b0, 4'd1);
    checkOutput("t3 bit0 toggle triggers", 32'(triggered), 1);
    repeat (14) applyStimulus(1'b0, 1'b0, 4'd1);
    checkOutput("t3 done", 32'(done), 1);
    readCheck("t3 rd trigger", 1, trigCyc);
    readCheck("t3 rd oldest", 0, trigCyc - 1);

    // Any-change with an empty mask never fires; abort returns to idle.
    trigMask = 4'h0; preTrigCount = 4'd0;
    applyStimulus(1'b1, 1'b0, 4'd0);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b0, TRIG_W'(i * 5));
    checkOutput("t3 mask0 no trigger", 32'(triggered), 0);
    checkOutput("t3 mask0 busy", 32'(busy), 1);
    applyStimulus(1'b0, 1'b1, 4'd0);
    checkOutput("t3 abort busy", 32'(busy), 0);
    checkOutput("t3 abort done", 32'(done), 0);
    applyStimulus(1'b0, 1'b0, 4'd3);
    checkOutput("t3 stays idle", 32'(busy), 0);

    // Pre-trigger depth 15 clamps to 14; level mode with empty mask always
    // matches, so the hits during prefill must be ignored.
    trigMode = 2'd0; preTrigCount = 4'd15;
    armCyc = cyc;
    applyStimulus(1'b1, 1'b0, 4'd0);
    repeat (14) applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t4 no trigger in prefill", 32'(triggered), 0);
    trigCyc = cyc;
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t4 triggered", 32'(triggered), 1);
    checkOutput("t4 not done at trigger", 32'(done), 0);
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t4 done after one post", 32'(done), 1);
    checkOutput("t4 trigIndex clamped", 32'(trigIndex), 14);
    readCheck("t4 rd trigger", 14, trigCyc);
    readCheck("t4 rd post", 15, trigCyc + 1);
    readCheck("t4 rd oldest", 0, armCyc + 1);

    // Immediate trigger with no pre-trigger samples.
    trigMask = 4'hF; trigMode = 2'd3; preTrigCount = 4'd0;
    armCyc = cyc;
    applyStimulus(1'b1, 1'b0, 4'd0);
    checkOutput("t5 not triggered at arm", 32'(triggered), 0);
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t5 triggered first sample", 32'(triggered), 1);
    repeat (14) applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t5 not done early", 32'(done), 0);
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t5 done", 32'(done), 1);
    checkOutput("t5 trigIndex", 32'(trigIndex), 0);
    readCheck("t5 rd 0", 0, armCyc + 1);
    readCheck("t5 rd 15", 15, armCyc + 16);

    // Trigger only during prefill is ignored; arm during POST is ignored.
    trigValue = 4'd5; trigMode = 2'd0; preTrigCount = 4'd4;
    applyStimulus(1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd5);
    repeat (7) applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t6 prefill hit ignored", 32'(triggered), 0);
    checkOutput("t6 still waiting", 32'(busy), 1);
    trigCyc = cyc;
    applyStimulus(1'b0, 1'b0, 4'd5);
    checkOutput("t6 triggered", 32'(triggered), 1);
    preTrigCount = 4'd2;
    applyStimulus(1'b1, 1'b0, 4'd5);
    checkOutput("t6 arm in post keeps triggered", 32'(triggered), 1);
    checkOutput("t6 arm in post keeps trigIndex", 32'(trigIndex), 4);
    repeat (9) applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t6 not done early", 32'(done), 0);
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t6 done", 32'(done), 1);
    readCheck("t6 rd trigger", 4, trigCyc);
    applyStimulus(1'b1, 1'b1, 4'd0);
    checkOutput("t6 arm+abort busy", 32'(busy), 0);
    checkOutput("t6 arm+abort done", 32'(done), 0);

    // Asynchronous reset in the middle of POST, then a clean re-arm.
    trigMode = 2'd3; preTrigCount = 4'd3;
    applyStimulus(1'b1, 1'b0, 4'd0);
    repeat (5) applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t7 triggered before reset", 32'(triggered), 1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("t7 reset busy", 32'(busy), 0);
    checkOutput("t7 reset triggered", 32'(triggered), 0);
    checkOutput("t7 reset done", 32'(done), 0);
    checkOutput("t7 reset trigIndex", 32'(trigIndex), 0);
    checkOutput("t7 reset rdData", 32'(rdData), 0);
    @(negedge sampleClk);
    resetN = 1'b1;
    preTrigCount = 4'd4;
    armCyc = cyc;
    applyStimulus(1'b1, 1'b0, 4'd0);
    repeat (4) applyStimulus(1'b0, 1'b0, 4'd0);
    trigCyc = cyc;
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t7 rearm triggered", 32'(triggered), 1);
    repeat (10) applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t7 rearm not done early", 32'(done), 0);
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t7 rearm done", 32'(done), 1);
    readCheck("t7 rd trigger", 4, trigCyc);
    readCheck("t7 rd oldest", 0, armCyc + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
